// File: rtl/ahb_params_pkg.sv
// AHB-Lite shared encodings for the interconnect return path.
// Transfer types, response codes, slave-select and default-slave states.
package ahb_params_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SRAM,
    SEL_DEFAULT
  } ahb_sel_e;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_e;

  function automatic logic is_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped transfers with the two-cycle ERROR.
// Outputs are registered alongside the state.
module ahb_default_slave
  import ahb_params_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q, state_d;
  logic      hreadyout_q, hreadyout_d;
  logic      hresp_q, hresp_d;
  logic      start;

  assign start = HREADY & HSEL & is_active(HTRANS);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE: if (start) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = start ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    hreadyout_d = (state_d != DS_ERR1);
    hresp_d     = (state_d == DS_IDLE) ? RESP_OKAY : RESP_ERROR;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= DS_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite data-phase return mux: registers the slave select and
// steers SRAM or default-slave response back to the master.
module ahb_resp_mux
  import ahb_params_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [1:0]        HTRANS,
  input  logic              HSEL_SRAM,
  input  logic              HSEL_DEFAULT,
  input  logic [DATA_W-1:0] HRDATA_SRAM,
  input  logic              HREADYOUT_SRAM,
  input  logic              HRESP_SRAM,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP
);

  ahb_sel_e sel_q, sel_d;
  logic     ds_hreadyout;
  logic     ds_hresp;
  logic     ds_hsel;

  // SRAM wins a double select, so the default slave must not start.
  assign ds_hsel = HSEL_DEFAULT & ~HSEL_SRAM;

  ahb_default_slave u_ds (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (ds_hsel),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (ds_hreadyout),
    .HRESP     (ds_hresp)
  );

  always_comb begin
    sel_d = sel_q;
    if (HREADY) begin
      if (HSEL_SRAM)         sel_d = SEL_SRAM;
      else if (HSEL_DEFAULT) sel_d = SEL_DEFAULT;
      else                   sel_d = SEL_NONE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) sel_q <= SEL_NONE;
    else        sel_q <= sel_d;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && HREADY)
      assert (!(HSEL_SRAM && HSEL_DEFAULT));
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = RESP_OKAY;
    unique case (sel_q)
      SEL_SRAM: begin
        HRDATA = HRDATA_SRAM;
        HREADY = HREADYOUT_SRAM;
        HRESP  = HRESP_SRAM;
      end
      SEL_DEFAULT: begin
        HREADY = ds_hreadyout;
        HRESP  = ds_hresp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Bench for ahb_resp_mux: directed vector table plus random
// traffic checked against a cycle-level transaction model.
module tb_ahb_resp_mux;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  HTRANS;
  logic        HSEL_SRAM, HSEL_DEFAULT;
  logic [31:0] HRDATA_SRAM;
  logic        HREADYOUT_SRAM, HRESP_SRAM;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP;

  int n_chk = 0;
  int n_fail = 0;

  // model: target of current data phase (0 none, 1 sram, 2 default)
  // and error cycles still owed by the default slave (2, 1, 0)
  int m_tgt = 0;
  int m_err = 0;

  always #5 HCLK = ~HCLK;

  ahb_resp_mux #(.DATA_W(32)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .HTRANS         (HTRANS),
    .HSEL_SRAM      (HSEL_SRAM),
    .HSEL_DEFAULT   (HSEL_DEFAULT),
    .HRDATA_SRAM    (HRDATA_SRAM),
    .HREADYOUT_SRAM (HREADYOUT_SRAM),
    .HRESP_SRAM     (HRESP_SRAM),
    .HRDATA         (HRDATA),
    .HREADY         (HREADY),
    .HRESP          (HRESP)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  trans;
    logic        hs;
    logic        hd;
    logic [31:0] rdata;
    logic        rdy;
    logic        resp;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_resp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic [1:0] tr, logic hs,
                              logic hd, logic [31:0] rd, logic rdy,
                              logic rsp, logic [31:0] ed, logic er,
                              logic ep);
    vec_t v;
    v.rst = rst; v.trans = tr; v.hs = hs; v.hd = hd;
    v.rdata = rd; v.rdy = rdy; v.resp = rsp;
    v.e_data = ed; v.e_rdy = er; v.e_resp = ep;
    return v;
  endfunction

  task automatic model_out(output logic [31:0] d, output logic r,
                           output logic p);
    d = 32'h0; r = 1'b1; p = 1'b0;
    if (m_tgt == 1) begin
      d = HRDATA_SRAM; r = HREADYOUT_SRAM; p = HRESP_SRAM;
    end else if (m_tgt == 2) begin
      r = (m_err != 2);
      p = (m_err != 0);
    end
  endtask

  task automatic check(string nm, logic [31:0] ed, logic er, logic ep);
    n_chk++;
    if (HRDATA !== ed || HREADY !== er || HRESP !== ep) begin
      n_fail++;
      $display("FAIL %s t=%0t got d=%h rdy=%b resp=%b want d=%h rdy=%b resp=%b",
               nm, $time, HRDATA, HREADY, HRESP, ed, er, ep);
    end
  endtask

  // drive one cycle (called just after a posedge), optionally check
  // at the negedge, then advance the model across the next posedge
  task automatic cycle(vec_t v, int mode, string nm);
    logic [31:0] md;
    logic mr, mp;
    HRESET = v.rst; HTRANS = v.trans;
    HSEL_SRAM = v.hs; HSEL_DEFAULT = v.hd;
    HRDATA_SRAM = v.rdata; HREADYOUT_SRAM = v.rdy; HRESP_SRAM = v.resp;
    @(negedge HCLK);
    model_out(md, mr, mp);
    if (mode == 1) check(nm, v.e_data, v.e_rdy, v.e_resp);
    if (mode == 2) check(nm, md, mr, mp);
    @(posedge HCLK);
    if (v.rst) begin
      m_tgt = 0; m_err = 0;
    end else begin
      if (m_err == 2)
        m_err = 1;
      else if (mr && v.hd && !v.hs && v.trans >= 2)
        m_err = 2;
      else
        m_err = 0;
      if (mr) m_tgt = v.hs ? 1 : (v.hd ? 2 : 0);
    end
    #1;
  endtask

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;

  initial begin
    vec_t v;
    // reset hold and release
    vt.push_back(mk(1, I, 0, 0, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(1, I, 0, 0, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 1, 0));
    // SRAM read with two wait states
    vt.push_back(mk(0, N, 1, 0, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, I, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, I, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, I, 0, 0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1, 0));
    vt.push_back(mk(0, I, 0, 0, 32'h5555_AAAA, 1, 1, 0, 1, 0));
    // unmapped access
    vt.push_back(mk(0, N, 0, 1, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 1, 1));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 1, 0));
    // back-to-back unmapped
    vt.push_back(mk(0, N, 0, 1, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, N, 0, 1, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, N, 0, 1, 0, 1, 0, 0, 1, 1));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 1, 1));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 1, 0));
    // error, cancel, then SEQ to SRAM during ERR2
    vt.push_back(mk(0, N, 0, 1, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, S, 1, 0, 0, 1, 0, 0, 1, 1));
    vt.push_back(mk(0, I, 0, 0, 32'h1234_5678, 1, 0, 32'h1234_5678, 1, 0));
    vt.push_back(mk(0, I, 0, 0, 32'h0, 0, 1, 0, 1, 0));
    // reset during ERR1
    vt.push_back(mk(0, N, 0, 1, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(1, I, 0, 0, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, I, 0, 0, 0, 1, 0, 0, 1, 0));
    // reset during an SRAM wait state
    vt.push_back(mk(0, N, 1, 0, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(1, I, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, I, 0, 0, 32'hFFFF_FFFF, 0, 1, 0, 1, 0));

    @(posedge HCLK); #1;
    cycle(mk(1, I, 0, 0, 0, 1, 0, 0, 1, 0), 0, "pre");

    foreach (vt[i]) cycle(vt[i], 1, $sformatf("vec%0d", i));

    for (int k = 0; k < 600; k++) begin
      int pick;
      pick = $urandom_range(0, 3);
      v.rst   = ($urandom_range(0, 59) == 0);
      v.trans = 2'($urandom_range(0, 3));
      v.hs    = (pick == 1);
      v.hd    = (pick == 2);
      v.rdata = $urandom;
      v.rdy   = ($urandom_range(0, 3) != 0);
      v.resp  = ($urandom_range(0, 7) == 0);
      v.e_data = 0; v.e_rdy = 0; v.e_resp = 0;
      cycle(v, 2, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux.md
# ahb_resp_mux

Data-phase return path of the AHB-Lite interconnect. Registers the address-phase slave select and steers the selected slave's HRDATA/HREADYOUT/HRESP back to the master as bus HRDATA/HREADY/HRESP. It contains the default slave, which returns the two-cycle ERROR response for unmapped addresses. It sits between the address decoder (HSEL_* inputs), the SRAM slave and the master.

## Interface
Parameters:
- DATA_W, 32, data bus width.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  reset, synchronous and active-high.
- HTRANS  in  2  master transfer type, address phase.
- HSEL_SRAM  in  1  decoder select for SRAM, address phase.
- HSEL_DEFAULT  in  1  decoder select for default slave, address phase.
- HRDATA_SRAM  in  DATA_W  SRAM read data.
- HREADYOUT_SRAM  in  1  SRAM ready.
- HRESP_SRAM  in  1  SRAM response (0 OKAY, 1 ERROR).
- HRDATA  out  DATA_W  muxed read data to master.
- HREADY  out  1  muxed ready. Also fed back to all slaves.
- HRESP  out  1  muxed response.

## Operation
- Data-phase select register sel_q ∈ {SEL_NONE, SEL_SRAM, SEL_DEFAULT}.
  - Loads only on a rising HCLK edge where HREADY=1.
  - Loads SEL_SRAM if HSEL_SRAM=1, else SEL_DEFAULT if HSEL_DEFAULT=1, else SEL_NONE.
  - Holds while HREADY=0.
- Both HSEL_* high in the same cycle is illegal. SRAM wins, and a simulation assertion fires.
- Output mux, combinational from sel_q and slave inputs:
  - SEL_NONE: HRDATA=0, HREADY=1, HRESP=0.
  - SEL_SRAM: pass HRDATA_SRAM, HREADYOUT_SRAM, HRESP_SRAM.
  - SEL_DEFAULT: HRDATA=0, HREADY/HRESP from the default-slave FSM.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE → DS_ERR1 when HREADY=1, HSEL_DEFAULT=1, HSEL_SRAM=0 and HTRANS ∈ {NONSEQ, SEQ}.
  - DS_ERR1: drives HREADYOUT=0, HRESP=1. Always → DS_ERR2.
  - DS_ERR2: drives HREADYOUT=1, HRESP=1. Goes → DS_ERR1 if the DS_IDLE entry condition holds again (back-to-back unmapped transfer), else → DS_IDLE.
  - DS_IDLE: drives HREADYOUT=1, HRESP=0.
- The master may change HTRANS to IDLE during DS_ERR1 (standard error cancel). The FSM still completes DS_ERR2.

## Timing
- Reset (HRESET=1 at an edge): sel_q=SEL_NONE, FSM=DS_IDLE. Outputs from the next cycle are HRDATA=0, HREADY=1, HRESP=0.
- Reset mid-transfer aborts any ERROR or SRAM data phase. No output pulse after reset.
- SRAM path has zero added latency: output equals the SRAM inputs in the same cycle, given sel_q.
- Unmapped transfer with address phase in cycle N:
  - Cycle N+1: HREADY=0, HRESP=1.
  - Cycle N+2: HREADY=1, HRESP=1.
  - The next address phase is accepted at the end of N+2.
- A SEL_NONE data phase (IDLE/BUSY address phase) completes in one cycle with OKAY.
- While HREADY=0, address-phase inputs are ignored by sel_q and by the FSM entry condition.

## Structure
- ahb_params_pkg (existing) gains:
  - ahb_sel_e {SEL_NONE, SEL_SRAM, SEL_DEFAULT}.
  - ds_state_e {DS_IDLE, DS_ERR1, DS_ERR2}.
  - HRESP constants RESP_OKAY=1'b0, RESP_ERROR=1'b1.
- NONSEQ/SEQ encodings come from the same package.
- One sub-module: ahb_default_slave. It holds the FSM, with inputs HCLK, HRESET, HSEL, HTRANS, HREADY and outputs HREADYOUT, HRESP.
- ahb_resp_mux instantiates ahb_default_slave and holds sel_q and the output mux.

## Test plan
- Reset: hold HRESET=1 for 3 cycles, then release with HTRANS=IDLE → HREADY=1, HRESP=0, HRDATA=0 every cycle.
- SRAM read: NONSEQ with HSEL_SRAM=1, then HREADYOUT_SRAM=0 for 2 cycles, then 1 with HRDATA_SRAM=32'hDEAD_BEEF → HREADY is 0,0,1 and HRDATA=32'hDEAD_BEEF on the final cycle; HRESP=0 throughout.
- Unmapped access: NONSEQ with HSEL_DEFAULT=1 in cycle N → (HREADY,HRESP)=(0,1) at N+1 and (1,1) at N+2, then (1,0) at N+3 if the next transfer is IDLE.
- Back-to-back unmapped: two consecutive NONSEQ to the default slave → ERR1, ERR2, ERR1, ERR2 with no OKAY cycle between the pairs.
- Mixed: default-slave error, then a SEQ to SRAM presented during DS_ERR2 → sel_q=SEL_SRAM next cycle and SRAM data is passed through.
- Reset during DS_ERR1 → next cycle HREADY=1, HRESP=0, FSM in DS_IDLE.
